// File: rtl/ram_fifo_ctl.sv
// FIFO controller driving a dual-port ram: port A writes, port B reads, one clock.
// Pointers, level and flags are held here; the ram is external.
module ram_fifo_ctl #(
  parameter int ADDRWID    = 8,
  parameter int DEPTH      = 1 << ADDRWID,
  parameter int AFULL_LVL  = DEPTH - 4,
  parameter int AEMPTY_LVL = 4
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               FLUSH,
  input  logic               PUSH,
  input  logic [17:0]        DIN,
  input  logic               POP,
  output logic [17:0]        DOUT,
  output logic               DOUT_VALID,
  output logic [ADDRWID:0]   LEVEL,
  output logic               FULL,
  output logic               EMPTY,
  output logic               ALMOST_FULL,
  output logic               ALMOST_EMPTY,
  output logic               OVERRUN,
  output logic               UNDERRUN,
  output logic [ADDRWID-1:0] AA,
  output logic [ADDRWID-1:0] AB,
  output logic               CENA,
  output logic               WENA,
  output logic [1:0]         WENBA,
  output logic [17:0]        DA,
  output logic               CENB,
  output logic               WENB,
  output logic [1:0]         WENBB,
  output logic [17:0]        DB,
  input  logic [17:0]        QB
);
  localparam logic [ADDRWID:0] DEPTH_L  = (ADDRWID+1)'(DEPTH);
  localparam logic [ADDRWID:0] AFULL_L  = (ADDRWID+1)'(AFULL_LVL);
  localparam logic [ADDRWID:0] AEMPTY_L = (ADDRWID+1)'(AEMPTY_LVL);

  logic [ADDRWID-1:0] wr_ptr, rd_ptr;
  logic [ADDRWID:0]   level;
  logic               dout_valid, overrun, underrun;
  logic               push_acc, pop_acc;

  assign FULL         = (level == DEPTH_L);
  assign EMPTY        = (level == '0);
  assign ALMOST_FULL  = (level >= AFULL_L);
  assign ALMOST_EMPTY = (level <= AEMPTY_L);

  // A pop frees the slot the concurrent push lands in, so push is allowed when full.
  assign push_acc = PUSH & (~FULL | POP) & ~FLUSH;
  assign pop_acc  = POP & ~EMPTY & ~FLUSH;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
    end else if (FLUSH) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      dout_valid <= pop_acc;
      if (PUSH & FULL & ~POP) overrun  <= 1'b1;
      if (POP & EMPTY)        underrun <= 1'b1;
    end
  end

  // Strobes are forced inactive while reset is held, whatever PUSH/POP do.
  assign CENA  = ~(push_acc & RESETN);
  assign WENA  = ~(push_acc & RESETN);
  assign WENBA = 2'b00;
  assign DA    = DIN;
  assign AA    = wr_ptr;

  assign CENB  = ~(pop_acc & RESETN);
  assign WENB  = 1'b1;
  assign WENBB = 2'b11;
  assign DB    = 18'h0;
  assign AB    = rd_ptr;

  assign DOUT       = QB;
  assign DOUT_VALID = dout_valid;
  assign LEVEL      = level;
  assign OVERRUN    = overrun;
  assign UNDERRUN   = underrun;
endmodule

// File: tb/tb_ram_fifo_ctl.sv
// Bench for ram_fifo_ctl: behavioural ram on the strobes plus a queue-based FIFO model.
module tb_ram_fifo_ctl;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          CLK = 1'b0;
  logic          RESETN, FLUSH, PUSH, POP;
  logic [17:0]   DIN, DOUT, DA, DB, QB;
  logic          DOUT_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERRUN, UNDERRUN;
  logic [AW:0]   LEVEL;
  logic [AW-1:0] AA, AB;
  logic          CENA, WENA, CENB, WENB;
  logic [1:0]    WENBA, WENBB;

  ram_fifo_ctl #(.ADDRWID(AW)) dut (
    .CLK(CLK), .RESETN(RESETN), .FLUSH(FLUSH), .PUSH(PUSH), .DIN(DIN), .POP(POP),
    .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .LEVEL(LEVEL), .FULL(FULL), .EMPTY(EMPTY),
    .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY), .OVERRUN(OVERRUN),
    .UNDERRUN(UNDERRUN), .AA(AA), .AB(AB), .CENA(CENA), .WENA(WENA), .WENBA(WENBA),
    .DA(DA), .CENB(CENB), .WENB(WENB), .WENBB(WENBB), .DB(DB), .QB(QB)
  );

  always #5 CLK = ~CLK;

  // ram: port B samples the address before port A's write on the same edge
  logic [17:0] mem [DEPTH];
  logic [17:0] qb_r;
  always @(posedge CLK) begin
    if (!CENB) qb_r <= mem[AB];
    if (!CENA && !WENA && WENBA == 2'b00) mem[AA] <= DA;
  end
  assign QB = qb_r;

  logic [17:0] q[$];
  bit          m_ovr, m_und, m_dv;
  logic [17:0] m_dout;
  int          m_wa, m_ra;
  int          errors = 0, checks = 0;

  task chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task model_clear;
    q.delete();
    m_ovr = 0; m_und = 0; m_dv = 0; m_wa = 0; m_ra = 0;
  endtask

  task chk_state;
    int n;
    n = q.size();
    chk("level",  32'(LEVEL), n);
    chk("full",   32'(FULL), 32'(n == DEPTH));
    chk("empty",  32'(EMPTY), 32'(n == 0));
    chk("afull",  32'(ALMOST_FULL), 32'(n >= DEPTH - 4));
    chk("aempty", 32'(ALMOST_EMPTY), 32'(n <= 4));
    chk("ovr",    32'(OVERRUN), 32'(m_ovr));
    chk("und",    32'(UNDERRUN), 32'(m_und));
    chk("dvalid", 32'(DOUT_VALID), 32'(m_dv));
    if (m_dv) chk("dout", 32'(DOUT), 32'(m_dout));
    chk("aa", 32'(AA), m_wa);
    chk("ab", 32'(AB), m_ra);
  endtask

  // one clock: drive at negedge, check strobes, advance model at posedge, check state at next negedge
  task cyc(input bit p, input logic [17:0] d, input bit o, input bit f);
    bit full, empty, pa, pp;
    PUSH = p; DIN = d; POP = o; FLUSH = f;
    #1;
    full  = (q.size() == DEPTH);
    empty = (q.size() == 0);
    pa = !f && p && (!full || o);
    pp = !f && o && !empty;
    chk("cena", 32'(CENA), 32'(!pa));
    chk("wena", 32'(WENA), 32'(!pa));
    chk("cenb", 32'(CENB), 32'(!pp));
    if (pa) chk("da", 32'(DA), 32'(d));
    @(posedge CLK);
    if (f) model_clear();
    else begin
      if (pp) begin m_dout = q.pop_front(); m_ra = (m_ra + 1) % DEPTH; end
      if (pa) begin q.push_back(d); m_wa = (m_wa + 1) % DEPTH; end
      if (p && full && !o) m_ovr = 1;
      if (o && empty) m_und = 1;
      m_dv = pp;
    end
    @(negedge CLK);
    chk_state();
  endtask

  // async reset asserted between edges with PUSH/POP held high
  task do_reset;
    RESETN = 1'b0; PUSH = 1'b1; POP = 1'b1; FLUSH = 1'b0;
    #1;
    model_clear();
    chk_state();
    chk("rst_cena", 32'(CENA), 32'd1);
    chk("rst_cenb", 32'(CENB), 32'd1);
    chk("rst_wena", 32'(WENA), 32'd1);
    @(negedge CLK);
    chk_state();
    RESETN = 1'b1; PUSH = 1'b0; POP = 1'b0;
  endtask

  initial begin
    bit p, o, f;
    int bias;
    RESETN = 1'b0; FLUSH = 1'b0; PUSH = 1'b0; POP = 1'b0; DIN = '0;
    @(negedge CLK);
    do_reset();
    chk("wenba", 32'(WENBA), 32'd0);
    chk("wenb",  32'(WENB), 32'd1);
    chk("wenbb", 32'(WENBB), 32'd3);
    chk("db",    32'(DB), 32'd0);

    // basic in/out
    for (int i = 1; i <= 3; i++) cyc(1, 18'(i), 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0);
    cyc(0, '0, 0, 0);

    // fill to full, then overrun
    for (int i = 0; i < DEPTH; i++) cyc(1, 18'(i), 0, 0);
    cyc(1, 18'h15555, 0, 0);
    // push+pop while full, then drain
    cyc(1, 18'h3ABCD, 1, 0);
    for (int i = 0; i < DEPTH; i++) cyc(0, '0, 1, 0);
    chk("last_word", 32'(DOUT), 32'h3ABCD);

    // empty pops
    cyc(0, '0, 1, 0);
    cyc(1, 18'h01234, 1, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 0, 0);

    // wrap with continuous streaming
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 250; i++) cyc(1, 18'(i + 1000), 0, 0);
    for (int i = 0; i < 300; i++) cyc(1, 18'(i + 5000), 1, 0);
    for (int i = 0; i < 251; i++) cyc(0, '0, 1, 0);

    // flush and mid-burst reset
    for (int i = 0; i < 10; i++) cyc(1, 18'(i + 77), 0, 0);
    cyc(1, 18'h11111, 1, 1);
    for (int i = 0; i < 5; i++) cyc(1, 18'(i + 300), i[0], 0);
    do_reset();
    cyc(1, 18'h2AAAA, 0, 0);
    cyc(1, 18'h15A5A, 1, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 0, 0);

    // randomized phases alternately biased toward full and empty
    for (int i = 0; i < 2000; i++) begin
      bias = ((i / 300) % 2 == 0) ? 75 : 25;
      p = ($urandom_range(99) < bias);
      o = ($urandom_range(99) < (100 - bias));
      f = ($urandom_range(299) == 0);
      cyc(p, 18'($urandom), o, f);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
